// File: rtl/pmem_burst_adaptor.sv
// Purpose: cache line <-> DRAM burst adaptor. Accepts one 256-bit line read or
//          write, runs it as a BEATS x BEAT_WIDTH burst, answers with a one-cycle
//          pmem_resp.
// Latency: request seen in IDLE at cycle 0 -> pmem_resp at cycle 5 when memory
//          returns a beat every cycle. Each cycle without burst_resp adds one cycle.
// Backpressure: the memory paces the burst via burst_resp. The cache holds its
//          request until pmem_resp. A new request is taken no earlier than
//          2 cycles after pmem_resp.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   pmem_read/pmem_write             line request from cache (write wins)
//   pmem_address, pmem_wdata         line address (offset bits ignored), write line
//   pmem_resp, pmem_rdata            completion pulse, line buffer contents
//   burst_read/burst_write           burst request, held for the whole burst
//   burst_address, burst_wdata       line-aligned address, current write beat
//   burst_rdata, burst_resp          returning read beat, beat-transferred strobe
module pmem_burst_adaptor #(
  parameter int BEATS      = 4,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pmem_read,
  input  logic                        pmem_write,
  input  logic [31:0]                 pmem_address,
  input  logic [BEATS*BEAT_WIDTH-1:0] pmem_wdata,
  output logic                        pmem_resp,
  output logic [BEATS*BEAT_WIDTH-1:0] pmem_rdata,
  output logic                        burst_read,
  output logic                        burst_write,
  output logic [31:0]                 burst_address,
  output logic [BEAT_WIDTH-1:0]       burst_wdata,
  input  logic [BEAT_WIDTH-1:0]       burst_rdata,
  input  logic                        burst_resp
);

  localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  // byte offset bits of a line address
  localparam int OFF = $clog2(BEATS * BEAT_WIDTH / 8);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    RESP,
    HOLD
  } state_t;

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]   line_q;
  logic [31-OFF:0]                    addr_q;
  logic                               accept_wr;
  logic                               accept_rd;
  logic                               beat_done;

  // offset bits of the request address are don't-care
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address[OFF-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state_q)
      IDLE: begin
        // write has priority; a concurrent read is taken later only if still held
        if (pmem_write) begin
          accept_wr = 1'b1;
          state_d   = WR_BURST;
        end else if (pmem_read) begin
          accept_rd = 1'b1;
          state_d   = RD_BURST;
        end
      end
      WR_BURST: if (burst_resp && cnt_q == LAST_BEAT) state_d = RESP;
      RD_BURST: if (burst_resp && cnt_q == LAST_BEAT) state_d = RESP;
      RESP:     state_d = HOLD;
      // cache drops its request during this cycle; never re-accept it here
      HOLD:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign beat_done = burst_resp && (state_q == WR_BURST || state_q == RD_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      if (accept_wr || accept_rd) begin
        addr_q <= pmem_address[31:OFF];
        cnt_q  <= '0;
      end
      if (accept_wr) begin
        line_q <= pmem_wdata;
      end
      if (beat_done) begin
        // wraps back to 0 after the last beat
        cnt_q <= cnt_q + 1'b1;
        if (state_q == RD_BURST) begin
          line_q[cnt_q] <= burst_rdata;
        end
      end
    end
  end

  assign pmem_resp     = (state_q == RESP);
  assign burst_write   = (state_q == WR_BURST);
  assign burst_read    = (state_q == RD_BURST);
  assign burst_address = {addr_q, {OFF{1'b0}}};
  assign burst_wdata   = line_q[cnt_q];
  assign pmem_rdata    = line_q;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
module tb_pmem_burst_adaptor;

  localparam int BEATS = 4;
  localparam int BW    = 64;
  localparam int LW    = BEATS * BW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           pmem_read = 1'b0;
  logic           pmem_write = 1'b0;
  logic [31:0]    pmem_address = '0;
  logic [LW-1:0]  pmem_wdata = '0;
  logic           pmem_resp;
  logic [LW-1:0]  pmem_rdata;
  logic           burst_read;
  logic           burst_write;
  logic [31:0]    burst_address;
  logic [BW-1:0]  burst_wdata;
  logic [BW-1:0]  burst_rdata;
  logic           burst_resp;

  pmem_burst_adaptor #(.BEATS(BEATS), .BEAT_WIDTH(BW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   addr;
    logic          is_wr;
    logic [LW-1:0] line;
  } exp_t;

  exp_t          burst_q[$];   // bursts the memory side should see, in order
  exp_t          resp_q[$];    // pmem_resp payloads the cache should see, in order
  logic [LW-1:0] mem [logic [26:0]];
  bit            resp_pat[$];  // forced burst_resp pattern, overrides stall_pct
  int            stall_pct = 0;
  int            stall_cnt = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] get_line(input logic [26:0] key);
    if (!mem.exists(key)) mem[key] = rand_line();
    return mem[key];
  endfunction

  // Memory model: answers bursts beat by beat, checks what the adaptor presents.
  initial begin : responder
    exp_t          cur;
    int            beat;
    bit            active;
    bit            last_done;
    bit            go;
    logic [LW-1:0] wl;
    logic [LW-1:0] ml;
    beat = 0; active = 0; last_done = 0; wl = '0;
    cur.addr = '0; cur.is_wr = 1'b0; cur.line = '0;
    burst_resp = 1'b0;
    burst_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        burst_resp = 1'b0; burst_rdata = '0;
        active = 0; last_done = 0; beat = 0;
        burst_q.delete();
      end else begin
        if (last_done) begin
          check("burst_drop", LW'({burst_read, burst_write}), '0);
          last_done = 0;
        end
        if (burst_read || burst_write) begin
          if (!active) begin
            if (burst_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_burst: rd=%0b wr=%0b with nothing outstanding", burst_read, burst_write);
              cur.addr = burst_address; cur.is_wr = burst_write; cur.line = '0;
            end else begin
              cur = burst_q.pop_front();
            end
            check("burst_address", LW'(burst_address), LW'(cur.addr));
            check("burst_kind", LW'({burst_read, burst_write}), LW'({~cur.is_wr, cur.is_wr}));
            active = 1; beat = 0;
          end
          if (burst_write) check("burst_wdata", LW'(burst_wdata), LW'(cur.line[beat*BW +: BW]));
          if (resp_pat.size() > 0) go = resp_pat.pop_front();
          else go = ($urandom_range(0, 99) >= stall_pct);
          if (!go) stall_cnt++;
          ml = get_line(cur.addr[31:5]);
          burst_resp = go;
          burst_rdata = go ? ml[beat*BW +: BW] : BW'({$urandom, $urandom});
          if (go) begin
            wl[beat*BW +: BW] = burst_wdata;
            beat++;
            if (beat == BEATS) begin
              if (cur.is_wr) mem[cur.addr[31:5]] = wl;
              active = 0; last_done = 1;
            end
          end
        end else begin
          burst_resp = 1'b0;
        end
      end
    end
  end

  // Cache-side monitor: every pmem_resp must match the oldest outstanding request.
  initial begin : monitor
    exp_t e;
    bit   prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_q.delete();
        prev = 0;
      end else if (pmem_resp) begin
        check("resp_pulse", LW'(prev), '0);
        if (resp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_resp: pmem_resp=1 with nothing outstanding");
        end else begin
          e = resp_q.pop_front();
          check(e.is_wr ? "wr_rdata" : "rd_rdata", pmem_rdata, e.line);
        end
        prev = 1;
      end else begin
        prev = 0;
      end
    end
  end

  task automatic push_exp(input bit wr, input logic [31:0] addr, input logic [LW-1:0] line);
    exp_t e;
    e.addr = addr & 32'hFFFF_FFE0;
    e.is_wr = wr;
    e.line = line;
    burst_q.push_back(e);
    resp_q.push_back(e);
  endtask

  task automatic wait_resp(output int lat, output bit got);
    lat = 0; got = 0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      got = pmem_resp;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL resp_timeout: no pmem_resp within %0d cycles", lat);
    end
  endtask

  // One complete line transaction; called only when the adaptor is idle.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                        input bit scramble);
    int lat;
    bit got;
    @(negedge clk);
    push_exp(wr, addr, wr ? wd : get_line(addr[31:5]));
    stall_cnt = 0;
    pmem_address = addr; pmem_wdata = wd;
    pmem_write = wr; pmem_read = !wr;
    lat = 0; got = 0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("burst_start", LW'(burst_read | burst_write), LW'(1));
        if (scramble) begin
          pmem_address = $urandom;
          pmem_wdata = rand_line();
        end
      end
      got = pmem_resp;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL resp_timeout: no pmem_resp within %0d cycles", lat);
    end else begin
      check("latency", LW'(lat), LW'(5 + stall_cnt));
    end
    @(negedge clk);
    pmem_read = 1'b0; pmem_write = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [LW-1:0] wd;
    logic [31:0]   a;
    int            lat;
    bit            got;

    // Reset asserted asynchronously, with a read request already pending.
    pmem_read = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs", LW'({pmem_resp, burst_read, burst_write, burst_address, burst_wdata}), '0);
    check("rst_rdata", pmem_rdata, '0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_read", LW'(burst_read), '0);
    end
    pmem_read = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Zero-wait line read.
    stall_pct = 0;
    mem[27'h91] = {64'hD, 64'hC, 64'hB, 64'hA};
    do_req(0, 32'h0000_1234, '0, 0);

    // Line write with two idle cycles before beat 2.
    wd = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    resp_pat = '{1, 1, 0, 0, 1, 1};
    do_req(1, 32'h0000_2040, wd, 0);
    check("mem_wline", mem[27'h102], wd);

    // Read and write together: write first, read taken two cycles after resp.
    a = 32'h0000_3300;
    wd = rand_line();
    @(negedge clk);
    push_exp(1, a, wd);
    push_exp(0, a, wd);
    pmem_address = a; pmem_wdata = wd;
    pmem_write = 1'b1; pmem_read = 1'b1;
    wait_resp(lat, got);
    @(negedge clk);
    pmem_write = 1'b0;
    check("sim_hold_idle", LW'({burst_read, burst_write}), '0);
    @(negedge clk);
    check("sim_idle_idle", LW'({burst_read, burst_write}), '0);
    @(negedge clk);
    check("sim_read_start", LW'({burst_read, burst_write}), LW'(2'b10));
    wait_resp(lat, got);
    @(negedge clk);
    pmem_read = 1'b0;

    // Back-to-back requests right after HOLD.
    do_req(0, 32'h0000_4000, '0, 0);
    do_req(1, 32'h0000_4020, rand_line(), 0);
    do_req(0, 32'h0000_4020, '0, 0);

    // Reset in the middle of a read, after beat 1.
    a = 32'h0000_5060;
    @(negedge clk);
    push_exp(0, a, get_line(a[31:5]));
    pmem_address = a; pmem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    pmem_read = 1'b0;
    #1;
    check("midrst_read", LW'(burst_read), '0);
    check("midrst_resp", LW'(pmem_resp), '0);
    check("midrst_addr", LW'(burst_address), '0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    mem[a[31:5]] = rand_line();
    do_req(0, a, '0, 0);

    // Randomized traffic over a small set of lines, memory stalls, mid-burst input churn.
    for (int i = 0; i < 40; i++) begin
      stall_pct = $urandom_range(0, 60);
      a = 32'h8000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      do_req($urandom_range(0, 1) == 1, a, rand_line(), 1);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
